mem_arbiter: RTL and testbench

- Shares one simple_memory-style port between NUM_REQ requesters, e.g. several AXI slave adapters or a DMA and an adapter.
- Grants are round-robin. One transaction is in flight at a time.
- A per-transaction timeout turns a hung memory into an error response instead of a bus lockup.
- Sits between the requesters' memory-side outputs and the single physical memory.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_arbiter_rr_picker.sv | 24 ++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types, constants and helpers for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select
// ports: req_i request vector, last_i previous grant, any_o some request set,
//        win_o first requester found scanning upward from last_i+1 with wrap
module rr_picker #(
  parameter int N  = 2,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] last_i,
  output logic          any_o,
  output logic [GW-1:0] win_o
);
  logic [GW-1:0] idx;
  // scanned from the far end so the nearest requester after last_i is assigned last and wins
  always_comb begin
    any_o = |req_i;
    win_o = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = GW'((int'(last_i) + k) % N);
      if (req_i[idx]) win_o = idx;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between NUM_REQ requesters
// ports: ACLK_i/ARESETN_i clock and async active-low reset;
//        req_* packed requester buses (requester 0 in LSBs) with one-cycle ready/err pulse
//        and shared rdata; mem_* single memory port, one transaction in flight;
//        TIMEOUT_CYCLES!=0 turns a silent memory into an error response
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                NUM_REQ        = 2,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 0,
  parameter logic [DATA_W-1:0] ERR_RDATA      = DATA_W'(ERR_RDATA_DEFAULT)
) (
  input  logic                       ACLK_i,
  input  logic                       ARESETN_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_wstrb_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [DATA_W-1:0]          req_rdata_o,
  output logic                       req_err_o,
  output logic                       mem_valid_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W-1:0]          mem_wdata_o,
  output logic [DATA_W/8-1:0]        mem_wstrb_o,
  input  logic                       mem_ready_i,
  input  logic [DATA_W-1:0]          mem_rdata_i
);
  localparam int SW = DATA_W / 8;
  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, win;
  logic [TW-1:0] timer_q, timer_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic err_q, err_d, valid_q, valid_d, any, expire;
  rr_picker #(.N(NUM_REQ), .GW(GW)) u_pick (
    .req_i (req_valid_i),
    .last_i(last_q),
    .any_o (any),
    .win_o (win)
  );
  // expiry only counts when memory stays silent; a same-cycle ready takes the normal path
  assign expire = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    timer_d = timer_q;
    valid_d = valid_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    ready_d = '0;
    rdata_d = '0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (any) begin
        grant_d = win;
        valid_d = 1'b1;
        addr_d = req_addr_i[slice_lo(int'(win), ADDR_W) +: ADDR_W];
        wdata_d = req_wdata_i[slice_lo(int'(win), DATA_W) +: DATA_W];
        wstrb_d = req_wstrb_i[slice_lo(int'(win), SW) +: SW];
        timer_d = '0;
        state_d = BUSY;
      end
      BUSY: if (mem_ready_i || expire) begin
        valid_d = 1'b0;
        addr_d = '0;
        wdata_d = '0;
        wstrb_d = '0;
        ready_d[grant_q] = 1'b1;
        rdata_d = mem_ready_i ? mem_rdata_i : ERR_RDATA;
        err_d = !mem_ready_i;
        last_d = grant_q;
        state_d = RESP;
      end else if (TIMEOUT_CYCLES != 0) begin
        timer_d = timer_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK_i or negedge ARESETN_i) begin
    if (!ARESETN_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= GW'(NUM_REQ - 1);
      timer_q <= '0;
      valid_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  assign req_ready_o = ready_q;
  assign req_rdata_o = rdata_q;
  assign req_err_o = err_q;
  assign mem_valid_o = valid_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transaction-level checking of mem_arbiter
module tb_mem_arbiter;
  localparam int N = 2, AW = 32, DW = 32, SW = DW / 8, TO = 8;
  localparam logic [DW-1:0] ERR = 32'hDEAD_BEEF;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [AW-1:0] addr [N];
  logic [DW-1:0] wdata [N];
  logic [SW-1:0] wstrb [N];
  logic [N*AW-1:0] addr_p;
  logic [N*DW-1:0] wdata_p;
  logic [N*SW-1:0] wstrb_p;
  logic [DW-1:0] req_rdata, mem_wdata, mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wstrb;
  logic req_err, mem_valid, mem_ready = 1'b0;
  int total = 0, bad = 0, last = N - 1;
  always #5 clk = ~clk;
  always_comb begin
    addr_p = '0;
    wdata_p = '0;
    wstrb_p = '0;
    for (int i = 0; i < N; i++) begin
      addr_p[i*AW +: AW] = addr[i];
      wdata_p[i*DW +: DW] = wdata[i];
      wstrb_p[i*SW +: SW] = wstrb[i];
    end
  end
  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .ACLK_i     (clk),
    .ARESETN_i  (rst_n),
    .req_valid_i(req_valid),
    .req_addr_i (addr_p),
    .req_wdata_i(wdata_p),
    .req_wstrb_i(wstrb_p),
    .req_ready_o(req_ready),
    .req_rdata_o(req_rdata),
    .req_err_o  (req_err),
    .mem_valid_o(mem_valid),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_wstrb_o(mem_wstrb),
    .mem_ready_i(mem_ready),
    .mem_rdata_i(mem_rdata)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic post(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    addr[r] = a;
    wdata[r] = d;
    wstrb[r] = s;
    req_valid[r] = 1'b1;
  endtask
  task automatic outputs_zero(input string tag);
    check({tag, "_mem_valid"}, mem_valid, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_wstrb"}, mem_wstrb, 0);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_rdata"}, req_rdata, 0);
    check({tag, "_err"}, req_err, 0);
  endtask
  // called at a falling edge while the arbiter idles with requests posted;
  // d is the BUSY cycle (1-based) in which memory answers, 0 or >TO means never
  task automatic txn(input int d, input logic [DW-1:0] erd, input bit drop, output int w);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    int lim;
    bit timed;
    w = -1;
    for (int k = 1; k <= N; k++) if (w < 0 && req_valid[(last + k) % N]) w = (last + k) % N;
    ea = addr[w];
    ed = wdata[w];
    es = wstrb[w];
    lim = (d == 0 || d > TO) ? TO : d;
    timed = (lim != d);
    mem_ready = 1'($urandom_range(0, 1));
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      check("busy_valid", mem_valid, 1);
      check("busy_addr", mem_addr, ea);
      check("busy_wdata", mem_wdata, ed);
      check("busy_wstrb", mem_wstrb, es);
      check("busy_noready", req_ready, 0);
      mem_ready = (i == d);
      mem_rdata = (i == d) ? erd : $urandom;
      if (drop && i == 1) req_valid[w] = 1'b0;
    end
    @(negedge clk);
    check("resp_ready", req_ready, 64'(1 << w));
    check("resp_rdata", req_rdata, timed ? ERR : erd);
    check("resp_err", req_err, timed);
    check("resp_mem_valid", mem_valid, 0);
    check("resp_mem_addr", mem_addr, 0);
    check("resp_mem_wdata", mem_wdata, 0);
    check("resp_mem_wstrb", mem_wstrb, 0);
    req_valid[w] = 1'b0;
    last = w;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(negedge clk);
    outputs_zero("idle");
    mem_ready = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int w;
    for (int i = 0; i < N; i++) begin
      addr[i] = '0;
      wdata[i] = '0;
      wstrb[i] = '0;
    end
    #1 rst_n = 1'b0;
    #1 outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    post(0, 32'h10, 32'h0, 4'h0);
    txn(2, 32'hA5A5_0001, 0, w);
    post(1, 32'h20, 32'h1234_5678, 4'hF);
    txn(1, $urandom, 0, w);
    post(0, $urandom, $urandom, 4'($urandom_range(0, 15)));
    post(1, $urandom, $urandom, 4'($urandom_range(0, 15)));
    for (int t = 0; t < 6; t++) begin
      txn($urandom_range(1, 3), $urandom, 0, w);
      post(w, $urandom, $urandom, 4'($urandom_range(0, 15)));
    end
    req_valid = '0;
    @(negedge clk);
    post(0, 32'h40, 32'h0, 4'h0);
    txn(0, $urandom, 0, w);
    post(1, 32'h44, 32'h55, 4'h1);
    txn(3, 32'h0BAD_F00D, 0, w);
    post(0, 32'h48, 32'h0, 4'h0);
    txn(TO, 32'h1111_2222, 0, w);
    post(1, 32'h4C, 32'h0, 4'h0);
    txn(2, 32'h3333_4444, 1, w);
    post(0, 32'h50, 32'h9, 4'h3);
    @(negedge clk);
    check("rst_busy_valid", mem_valid, 1);
    #2 rst_n = 1'b0;
    #1 outputs_zero("async_reset");
    req_valid = '0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    outputs_zero("held_reset");
    rst_n = 1'b1;
    last = N - 1;
    post(1, 32'h60, 32'h0, 4'h0);
    txn(1, 32'h6060_6060, 0, w);
    post(0, 32'h64, 32'h0, 4'h0);
    post(1, 32'h68, 32'h0, 4'h0);
    txn(2, 32'h6464_6464, 0, w);
    txn(1, 32'h6868_6868, 0, w);
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < N; r++)
        if (!req_valid[r] && $urandom_range(0, 1)) post(r, $urandom, $urandom, 4'($urandom_range(0, 15)));
      if (req_valid == '0) post($urandom_range(0, N - 1), $urandom, $urandom, 4'($urandom_range(0, 15)));
      txn($urandom_range(0, 10), $urandom, $urandom_range(0, 7) == 0, w);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
